// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the N-channel memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Channel visited at step 'off' of a round-robin scan that starts after 'last'.
    function automatic int rr_index(input int last, input int off, input int n);
        return (last + off) % n;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of core-side channel buses and the downstream memory port.
interface mem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]                  port_valid;
    logic [NUM_PORTS-1:0]                  port_instr;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_wdata;
    logic [NUM_PORTS-1:0][STRB_WIDTH-1:0]  port_wstrb;
    logic [DATA_WIDTH-1:0]                 port_rdata;
    logic [NUM_PORTS-1:0]                  port_ready;

    logic                                  mem_valid;
    logic                                  mem_instr;
    logic [ADDR_WIDTH-1:0]                 mem_addr;
    logic [DATA_WIDTH-1:0]                 mem_wdata;
    logic [STRB_WIDTH-1:0]                 mem_wstrb;
    logic [DATA_WIDTH-1:0]                 mem_rdata;
    logic                                  mem_ready;

    // master: the cores plus the memory bus; slave: the arbiter between them
    modport master (
        output port_valid, port_instr, port_addr, port_wdata, port_wstrb, mem_rdata, mem_ready,
        input  port_rdata, port_ready, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
    );
    modport slave (
        input  port_valid, port_instr, port_addr, port_wdata, port_wstrb, mem_rdata, mem_ready,
        output port_rdata, port_ready, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arbiter_rr_select.sv
// Combinational round-robin picker: first set request after 'last', one-hot and index.
module rr_select
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);
    logic [NUM_PORTS-1:0][IDX_W-1:0] cand;

    always_comb begin
        cand = '0;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand[off-1] = IDX_W'(rr_index(int'(last), off, NUM_PORTS));
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!any && req[cand[k]]) begin
                any          = 1'b1;
                gnt[cand[k]] = 1'b1;
                idx          = cand[k];
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// N-channel round-robin memory arbiter, one outstanding downstream request.
// Define MEM_ARBITER_BYPASS_EN to forward a request from an idle, empty arbiter in the same cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = idx_w(NUM_PORTS);

    // Entry layout follows the module parameters, so it lives here rather than in the package.
    typedef struct packed {
        logic                  instr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } entry_t;

    arb_state_e                  state_q, state_d;
    logic [NUM_PORTS-1:0]        pending_q, pending_d;
    entry_t [NUM_PORTS-1:0]      entry_q, entry_d;
    logic [IDX_W-1:0]            grant_q, grant_d;
    logic [IDX_W-1:0]            last_q, last_d;
    entry_t                      hold_q, hold_d;

    entry_t [NUM_PORTS-1:0]      req_in;
    entry_t                      pend_sel, mem_out;
    logic [NUM_PORTS-1:0]        pend_gnt, clr, byp_take, port_ready;
    logic [IDX_W-1:0]            pend_idx;
    logic                        pend_any, mem_valid;

    rr_select #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_pend_pick (
        .req(pending_q), .last(last_q), .gnt(pend_gnt), .idx(pend_idx), .any(pend_any)
    );

`ifdef MEM_ARBITER_BYPASS_EN
    entry_t                      byp_sel;
    logic [NUM_PORTS-1:0]        byp_gnt;
    logic [IDX_W-1:0]            byp_idx;
    logic                        byp_any;

    rr_select #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_byp_pick (
        .req(bus.port_valid), .last(last_q), .gnt(byp_gnt), .idx(byp_idx), .any(byp_any)
    );
`endif

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_in[i] = '{instr: bus.port_instr[i], addr: bus.port_addr[i],
                          wdata: bus.port_wdata[i], wstrb: bus.port_wstrb[i]};
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        entry_d    = entry_q;
        grant_d    = grant_q;
        last_d     = last_q;
        hold_d     = hold_q;
        mem_valid  = 1'b0;
        mem_out    = hold_q;
        port_ready = '0;
        clr        = '0;
        byp_take   = '0;
        pend_sel   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pend_gnt[i]) pend_sel = pend_sel | entry_q[i];
        end
`ifdef MEM_ARBITER_BYPASS_EN
        byp_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (byp_gnt[i]) byp_sel = byp_sel | req_in[i];
        end
`endif
        case (state_q)
            IDLE: begin
                if (pend_any) begin
                    mem_valid = 1'b1;
                    mem_out   = pend_sel;
                    hold_d    = pend_sel;
                    grant_d   = pend_idx;
                    state_d   = WAIT;
                end
`ifdef MEM_ARBITER_BYPASS_EN
                else if (byp_any) begin
                    // Winner is served straight from the port; only the losers get latched.
                    mem_valid = 1'b1;
                    mem_out   = byp_sel;
                    hold_d    = byp_sel;
                    grant_d   = byp_idx;
                    byp_take  = byp_gnt;
                    state_d   = WAIT;
                end
`endif
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    port_ready[grant_q] = 1'b1;
                    clr[grant_q]        = 1'b1;
                    last_d              = grant_q;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new request in the completion cycle wins over the clear; otherwise repeats are dropped.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (clr[i]) pending_d[i] = 1'b0;
            if (bus.port_valid[i] && !byp_take[i] && (!pending_q[i] || clr[i])) begin
                pending_d[i] = 1'b1;
                entry_d[i]   = req_in[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            entry_q   <= '0;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_PORTS - 1);
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            entry_q   <= entry_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.mem_valid  = mem_valid;
    assign bus.mem_instr  = mem_out.instr;
    assign bus.mem_addr   = mem_out.addr;
    assign bus.mem_wdata  = mem_out.wdata;
    assign bus.mem_wstrb  = mem_out.wstrb;
    assign bus.port_ready = port_ready;
    assign bus.port_rdata = bus.mem_rdata;

endmodule
